rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the integer register file's single write port between two write-back requesters:
//   port 0 = ALU write-back, port 1 = load-data return.
//  Keeps a 32-bit busy scoreboard so decode stalls on RAW hazards for writes not yet performed.
//  Sits between the WB/LSU stages and the register file; drives its we/wd/wdata from registers.
// PARAMETERS
//  DATA_W    32  write-data width (matches RegBus)
//  ADDR_W    5   register-address width (matches RegAddrBus)
//  NUM_REGS  32  scoreboard depth; must equal 2**ADDR_W
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  req_v_i    in   2       per-port write request valid
//  req_rdy_o  out  2       per-port accept; a transfer occurs when req_v_i[k] && req_rdy_o[k]
//  req_addr_i in   2*ADDR_W  per-port destination register; port k at [k*ADDR_W +: ADDR_W]
//  req_data_i in   2*DATA_W  per-port write data
//  iss_e_i    in   1       decode issued an instruction that will write iss_addr_i
//  iss_addr_i in   ADDR_W  destination register of the issued instruction
//  rs1addr_i  in   ADDR_W  decode source-1 address for hazard query
//  rs2addr_i  in   ADDR_W  decode source-2 address for hazard query
//  rs1busy_o  out  1       rs1addr_i has a pending, unperformed write
//  rs2busy_o  out  1       rs2addr_i has a pending, unperformed write
//  we_o       out  1       register-file write enable (registered)
//  wd_o       out  ADDR_W  register-file write address (registered)
//  wdata_o    out  DATA_W  register-file write data (registered)
// BEHAVIOUR
//  Reset (rst=0, async): we_o=0, wd_o=0, wdata_o=0, busy=0, priority pointer=0.
//   An accepted request not yet written when reset asserts is dropped.
//  The output register always drains because the register file never stalls.
//   req_rdy_o is therefore the combinational grant: exactly one bit set when any req_v_i is high.
//   No grant when neither request is valid.
//   req_rdy_o never depends on req_rdy_o of the same cycle.
//  Latency: a transfer at edge N gives we_o=1, wd_o and wdata_o valid in cycle N+1.
//   The register file writes at edge N+1. Throughput is one write per cycle.
//  Accepted write to x0 (addr 0): consumed, but we_o=0 next cycle. No scoreboard effect.
//  No valid transfer: we_o=0 next cycle. wd_o and wdata_o hold their previous values.
//  Both requests target the same address: serialized in grant order; the later grant's data persists.
//  Scoreboard busy[NUM_REGS-1:0]:
//   - Set at the edge where iss_e_i=1 and iss_addr_i!=0.
//   - Cleared at the edge where we_o=1, for bit wd_o.
//   - Simultaneous set and clear of the same bit: set wins (a newer producer is in flight).
//   - busy[0] is constantly 0.
//  Hazard query, combinational:
//   rsXbusy_o = busy[rsXaddr_i] && !(we_o && wd_o==rsXaddr_i).
//   The in-cycle write is not a hazard because the register file forwards wdata to its read ports.
//   rsXbusy_o=0 when rsXaddr_i==0.
// CONFIGURATION
//  RF_WB_RR_EN defined:
//   - Round-robin between the two ports.
//   - 1-bit pointer names the preferred port.
//   - After any grant, the pointer moves to the other port.
//   - The pointer is unchanged in cycles with no grant.
//  RF_WB_RR_EN undefined:
//   - Fixed priority, port 1 (load return) wins ties.
//   - Pointer logic is removed.
//   - Port 0 may starve; upstream guarantees load bursts are bounded.
// STRUCTURE
//  Width and count constants (DATA_W, ADDR_W, NUM_REGS, ZeroWord) live in defines.v.
//  The per-port index encoding also lives in defines.v, shared with WB and LSU.
//  One sub-module: rf_wb_rr_arb.
//   - 2-way grant logic (fixed/RR selected by RF_WB_RR_EN), with its pointer flop.
//   - Outputs a one-hot grant and the granted index.
//  Top level holds the output register, the scoreboard and the query muxes.
// TESTING
//  1. Reset mid-write:
//     Port 0 transfers addr 5, data 0x1234; rst=0 before the next edge -> we_o=0, wdata_o=0, busy=0.
//  2. Single request:
//     iss 7; port 0 sends addr 7, 0xDEADBEEF at edge N.
//     -> cycle N+1: we_o=1, wd_o=7, rs1busy_o(7)=0; busy[7]=0 after edge N+1.
//  3. Contention, both valid 4 cycles (p0 addr 1, p1 addr 2):
//     -> RR: grants alternate, starting with p0 after reset.
//     -> fixed: p1 granted every cycle, req_rdy_o[0]=0.
//  4. x0 write: port 1 sends addr 0, data 0xFFFFFFFF -> req_rdy_o[1]=1, we_o=0 next cycle, busy unchanged.
//  5. Same-edge set/clear:
//     we_o=1, wd_o=9 while iss_e_i=1, iss_addr_i=9 -> busy[9]=1 after the edge.
//     -> rs2busy_o(9)=1 the following cycle.
//  6. Back-to-back:
//     4 consecutive port-0 transfers to addrs 3,4,5,6 -> we_o=1 for 4 consecutive cycles, in order.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Widths, register count, reset word and the per-port index encoding
// used by WB (port 0) and LSU (port 1).
package rf_wb_arbiter_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_NUM_PORTS = 2;

  localparam logic [RF_DATA_W-1:0] ZERO_WORD = '0;

  // Requester index encoding: bit position in req_v_i / req_rdy_o.
  localparam logic PORT_ALU = 1'b0;
  localparam logic PORT_LSU = 1'b1;

endpackage

// File: rtl/rf_wb_rr_arb.sv
// Two-way grant logic for the register-file write port.
// Ports: clk/rst (round-robin build only), req_v request vector,
//   gnt one-hot grant (zero when idle), gnt_idx index of the granted port.
// RF_WB_RR_EN defined: round-robin with a 1-bit preferred-port pointer.
// RF_WB_RR_EN undefined: fixed priority, load return (port 1) wins.
module rf_wb_rr_arb
  import rf_wb_arbiter_pkg::*;
(
`ifdef RF_WB_RR_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic [1:0] req_v,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

`ifdef RF_WB_RR_EN
  // ptr names the port preferred on a tie.
  logic ptr;

  always_comb begin
    gnt = req_v;
    if (req_v == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  // After a grant, the other port becomes preferred; idle cycles hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (|req_v) begin
      ptr <= ~gnt[PORT_LSU];
    end
  end
`else
  // Load return always wins a tie; bounded load bursts keep port 0 alive.
  always_comb begin
    gnt = req_v;
    if (req_v == 2'b11) begin
      gnt = 2'b10;
    end
  end
`endif

  assign gnt_idx = gnt[PORT_LSU];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the integer register file write port between ALU write-back (port 0)
// and load-data return (port 1), and tracks a busy scoreboard for RAW stalls.
// Ports: clk, rst (async active-low); req_v_i/req_rdy_o/req_addr_i/req_data_i
//   per-port write requests; iss_e_i/iss_addr_i mark a destination busy at issue;
//   rs1addr_i/rs2addr_i -> rs1busy_o/rs2busy_o hazard query; we_o/wd_o/wdata_o
//   registered register-file write. Transfer at edge N -> write visible in N+1.
// Optional macro RF_WB_RR_EN selects round-robin instead of fixed priority.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS   // must equal 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_v_i,
  output logic [1:0]          req_rdy_o,
  input  logic [2*ADDR_W-1:0] req_addr_i,
  input  logic [2*DATA_W-1:0] req_data_i,
  input  logic                iss_e_i,
  input  logic [ADDR_W-1:0]   iss_addr_i,
  input  logic [ADDR_W-1:0]   rs1addr_i,
  input  logic [ADDR_W-1:0]   rs2addr_i,
  output logic                rs1busy_o,
  output logic                rs2busy_o,
  output logic                we_o,
  output logic [ADDR_W-1:0]   wd_o,
  output logic [DATA_W-1:0]   wdata_o
);

  logic [1:0]          gnt;
  logic                gnt_idx;
  logic                xfer;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  logic                we_q;
  logic [ADDR_W-1:0]   wd_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // The register file never stalls, so the output register always drains and
  // the grant can be handed straight back as ready.
  rf_wb_rr_arb u_arb (
`ifdef RF_WB_RR_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .req_v   (req_v_i),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_rdy_o = gnt;
  assign xfer      = |gnt;

  always_comb begin
    sel_addr = req_addr_i[0 +: ADDR_W];
    sel_data = req_data_i[0 +: DATA_W];
    if (gnt_idx == PORT_LSU) begin
      sel_addr = req_addr_i[ADDR_W +: ADDR_W];
      sel_data = req_data_i[DATA_W +: DATA_W];
    end
  end

  // Writes to x0 are consumed but never reach the register file. Address and
  // data only move on an accepted transfer; idle cycles hold them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      wd_q    <= '0;
      wdata_q <= ZERO_WORD;
    end else begin
      we_q <= xfer && (sel_addr != '0);
      if (xfer) begin
        wd_q    <= sel_addr;
        wdata_q <= sel_data;
      end
    end
  end

  assign we_o    = we_q;
  assign wd_o    = wd_q;
  assign wdata_o = wdata_q;

  // Scoreboard: issue sets, the performed write clears. Set is applied after
  // clear so a newer producer issued on the same edge keeps the bit busy.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_e_i && (iss_addr_i != '0)) begin
      set_vec = NUM_REGS'(1) << iss_addr_i;
    end
    if (we_q) begin
      clr_vec = NUM_REGS'(1) << wd_q;
    end
    busy_nxt    = (busy & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // A write being performed this cycle is forwarded by the register file,
  // so it is not reported as a hazard.
  assign rs1busy_o = (rs1addr_i != '0) && busy[rs1addr_i] &&
                     !(we_q && (wd_q == rs1addr_i));
  assign rs2busy_o = (rs2addr_i != '0) && busy[rs2addr_i] &&
                     !(we_q && (wd_q == rs2addr_i));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_v = '0;
  logic [1:0]  req_rdy;
  logic [9:0]  req_addr = '0;
  logic [63:0] req_data = '0;
  logic        iss_e = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [4:0]  rs1addr = '0;
  logic [4:0]  rs2addr = '0;
  logic        rs1busy, rs2busy, we;
  logic [4:0]  wd;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  wd;
    logic [31:0] wdata;
  } wr_t;

  typedef struct packed {
    logic [1:0]  v;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  r1;
    logic [4:0]  r2;
  } stim_t;

  // Reference model state
  wr_t         exp_q[$];
  logic [31:0] m_busy = '0;
  logic        m_ptr = 1'b0;
  logic        m_we = 1'b0;
  logic [4:0]  m_wd = '0;
  logic [31:0] m_wdata = '0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst_n),
    .req_v_i    (req_v),
    .req_rdy_o  (req_rdy),
    .req_addr_i (req_addr),
    .req_data_i (req_data),
    .iss_e_i    (iss_e),
    .iss_addr_i (iss_addr),
    .rs1addr_i  (rs1addr),
    .rs2addr_i  (rs2addr),
    .rs1busy_o  (rs1busy),
    .rs2busy_o  (rs2busy),
    .we_o       (we),
    .wd_o       (wd),
    .wdata_o    (wdata)
  );

  function automatic stim_t mk(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                               input logic [4:0] a1, input logic [31:0] d1, input logic ie,
                               input logic [4:0] ia, input logic [4:0] r1, input logic [4:0] r2);
    stim_t s;
    s.v = v; s.a0 = a0; s.d0 = d0; s.a1 = a1; s.d1 = d1;
    s.ie = ie; s.ia = ia; s.r1 = r1; s.r2 = r2;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    req_v    = s.v;
    req_addr = {s.a1, s.a0};
    req_data = {s.d1, s.d0};
    iss_e    = s.ie;
    iss_addr = s.ia;
    rs1addr  = s.r1;
    rs2addr  = s.r2;
  endtask

  task automatic model_reset();
    m_busy  = '0;
    m_ptr   = 1'b0;
    m_we    = 1'b0;
    m_wd    = '0;
    m_wdata = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  // One clock: samples grant/hazard at the falling edge, pushes the expected
  // register-file write, then pops it after the rising edge against the DUT.
  // Vector layout: {rdy[1:0], rs1busy, rs2busy, we, wd[4:0], wdata[31:0]}.
  task automatic run_cycle(output logic [41:0] exp_vec, output logic [41:0] got_vec);
    logic [1:0]  e_rdy;
    logic        e1, e2;
    logic [31:0] nb;
    wr_t         w, ew;
    @(negedge clk);
    e_rdy = req_v;
    if (req_v == 2'b11) begin
`ifdef RF_WB_RR_EN
      e_rdy = m_ptr ? 2'b10 : 2'b01;
`else
      e_rdy = 2'b10;
`endif
    end
    e1 = (rs1addr != 5'd0) && m_busy[rs1addr] && !(m_we && m_wd == rs1addr);
    e2 = (rs2addr != 5'd0) && m_busy[rs2addr] && !(m_we && m_wd == rs2addr);
    exp_vec[41:38] = {e_rdy, e1, e2};
    got_vec[41:38] = {req_rdy, rs1busy, rs2busy};
    nb = m_busy;
    if (m_we) nb[m_wd] = 1'b0;
    if (iss_e && iss_addr != 5'd0) nb[iss_addr] = 1'b1;
    if (|e_rdy) begin
      w.wd    = e_rdy[1] ? req_addr[9:5] : req_addr[4:0];
      w.wdata = e_rdy[1] ? req_data[63:32] : req_data[31:0];
      w.we    = (w.wd != 5'd0);
`ifdef RF_WB_RR_EN
      m_ptr = ~e_rdy[1];
`endif
    end else begin
      w.we = 1'b0; w.wd = m_wd; w.wdata = m_wdata;
    end
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    m_busy = nb; m_we = w.we; m_wd = w.wd; m_wdata = w.wdata;
    ew = exp_q.pop_front();
    exp_vec[37:0] = ew;
    got_vec[37:0] = {we, wd, wdata};
  endtask

  task automatic test_reset();
    stim_t s[2];
    logic [41:0] e, g;
    #12;
    checks++;
    if ({we, wd, wdata, req_rdy, rs1busy} !== 41'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", {we, wd, wdata, req_rdy, rs1busy});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    s[0] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0);
    s[1] = mk(2'b01, 5'd5, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
    for (int i = 0; i < 2; i++) begin
      apply(s[i]);
      run_cycle(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_prewrite[%0d]: got %h expected %h", i, g, e);
      end
    end
    // Write now sits in the output register; reset must drop it immediately.
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({we, wd, wdata, rs1busy} !== 39'd0) begin
      errors++;
      $display("FAIL reset_midwrite: got %h expected 0", {we, wd, wdata, rs1busy});
    end
    apply(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0));
    #2;
    rst_n = 1'b1;
    run_cycle(e, g);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL reset_after: got %h expected %h", g, e);
    end
  endtask

  task automatic test_single();
    stim_t s[4];
    logic [41:0] e, g;
    s[0] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
    s[1] = mk(2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    s[2] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    s[3] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      run_cycle(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL single[%0d]: got %h expected %h", i, g, e);
      end
      if (i == 1) begin
        checks++;
        if ({g[37:0]} !== {1'b1, 5'd7, 32'hDEADBEEF}) begin
          errors++;
          $display("FAIL single_write: got %h expected %h", g[37:0], {1'b1, 5'd7, 32'hDEADBEEF});
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [41:0] e, g;
    logic [1:0]  want [4];
`ifdef RF_WB_RR_EN
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
`else
    for (int i = 0; i < 4; i++) want[i] = 2'b10;
`endif
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(mk(2'b11, 5'd1, 32'hA000_0000 + i, 5'd2, 32'hB000_0000 + i, 1'b0, 5'd0, 5'd0, 5'd0));
      run_cycle(e, g);
      checks++;
      if (g !== e || g[41:40] !== want[i]) begin
        errors++;
        $display("FAIL contention[%0d]: got %h expected %h grant %b", i, g, e, want[i]);
      end
    end
  endtask

  task automatic test_x0();
    stim_t s[3];
    logic [41:0] e, g;
    s[0] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd12, 5'd0);
    s[1] = mk(2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd12, 5'd0);
    s[2] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      run_cycle(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL x0[%0d]: got %h expected %h", i, g, e);
      end
      if (i == 1) begin
        checks++;
        if ({g[41:40], g[37]} !== 3'b100) begin
          errors++;
          $display("FAIL x0_accept: got rdy=%b we=%b expected rdy=10 we=0", g[41:40], g[37]);
        end
      end
    end
  endtask

  task automatic test_same_edge();
    stim_t s[4];
    logic [41:0] e, g;
    s[0] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd9);
    s[1] = mk(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
    s[2] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd9);
    s[3] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      run_cycle(e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL same_edge[%0d]: got %h expected %h", i, g, e);
      end
    end
    checks++;
    if (g[38] !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_setwins: got rs2busy=%b expected 1", g[38]);
    end
  endtask

  task automatic test_back_to_back();
    logic [41:0] e, g;
    for (int i = 0; i < 4; i++) begin
      apply(mk(2'b01, 5'(3 + i), 32'h300 + i, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0));
      run_cycle(e, g);
      checks++;
      if (g !== e || g[37:32] !== {1'b1, 5'(3 + i)}) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, g, e);
      end
    end
    apply(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0));
    run_cycle(e, g);
    checks++;
    if (g !== e || g[37] !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_idle: got %h expected %h", g, e);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_same_edge();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
